// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: memory-op encoding, FSM states and helpers.
package lsu_pkg;

    localparam int unsigned BYTE_LANES = 4;

    typedef logic [31:0] word_t;

    // Bit 3 separates stores from loads; bit 2 marks unsigned loads.
    typedef enum logic [3:0] {
        OpLb  = 4'b0000,
        OpLh  = 4'b0001,
        OpLw  = 4'b0010,
        OpLbu = 4'b0100,
        OpLhu = 4'b0101,
        OpSb  = 4'b1000,
        OpSh  = 4'b1001,
        OpSw  = 4'b1010
    } memop_e;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StWait,
        StDone
    } lsu_state_e;

    function automatic logic is_load(memop_e op);
        return !op[3];
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extraction and
// misalignment detection.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  memop_e                  op_i,
    input  logic [1:0]              off_i,
    input  logic [XLEN-1:0]         wdata_i,
    input  logic [XLEN-1:0]         mem_rdata_i,
    output logic [BYTE_LANES-1:0]   be_o,
    output logic [XLEN-1:0]         wdata_rep_o,
    output logic [XLEN-1:0]         load_data_o,
    output logic                    misaligned_o
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        be_o         = '0;
        wdata_rep_o  = wdata_i;
        misaligned_o = 1'b0;
        case (op_i)
            OpLb, OpLbu, OpSb: begin
                be_o        = 4'b0001 << off_i;
                wdata_rep_o = {(XLEN/8){wdata_i[7:0]}};
            end
            OpLh, OpLhu, OpSh: begin
                be_o         = off_i[1] ? 4'b1100 : 4'b0011;
                wdata_rep_o  = {(XLEN/16){wdata_i[15:0]}};
                misaligned_o = off_i[0];
            end
            OpLw, OpSw: begin
                be_o         = 4'b1111;
                misaligned_o = (off_i != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted     = mem_rdata_i >> {off_i, 3'b000};
        load_data_o = '0;
        case (op_i)
            OpLb:    load_data_o = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            OpLbu:   load_data_o = {{(XLEN-8){1'b0}}, shifted[7:0]};
            OpLh:    load_data_o = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            OpLhu:   load_data_o = {{(XLEN-16){1'b0}}, shifted[15:0]};
            OpLw:    load_data_o = shifted;
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one req/gnt/rvalid data-memory transaction per accepted op.
// Optional bus watchdog enabled by defining LSU_TIMEOUT_EN.
module lsu
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  memop_e                req_op,
    input  logic [XLEN-1:0]       req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  stall,
    output logic                  done,
    output logic [XLEN-1:0]       rdata,
    output logic                  misaligned,
    output logic                  bus_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [XLEN-1:0]       mem_addr,
    output logic [BYTE_LANES-1:0] mem_be,
    output logic [XLEN-1:0]       mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [XLEN-1:0]       mem_rdata
);

    lsu_state_e            state_q, state_d;
    memop_e                op_q, op_d;
    logic [1:0]            off_q, off_d;
    logic                  mem_we_q, mem_we_d;
    logic [XLEN-1:0]       mem_addr_q, mem_addr_d;
    logic [BYTE_LANES-1:0] mem_be_q, mem_be_d;
    logic [XLEN-1:0]       mem_wdata_q, mem_wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  misaligned_q, misaligned_d;
    logic                  expire;

    memop_e                al_op;
    logic [1:0]            al_off;
    logic [BYTE_LANES-1:0] al_be;
    logic [XLEN-1:0]       al_wdata;
    logic [XLEN-1:0]       al_load;
    logic                  al_mis;

    // In IDLE the aligner sees the incoming request; afterwards it sees the latched op.
    assign al_op  = (state_q == StIdle) ? req_op : op_q;
    assign al_off = (state_q == StIdle) ? req_addr[1:0] : off_q;

    lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .op_i         (al_op),
        .off_i        (al_off),
        .wdata_i      (req_wdata),
        .mem_rdata_i  (mem_rdata),
        .be_o         (al_be),
        .wdata_rep_o  (al_wdata),
        .load_data_o  (al_load),
        .misaligned_o (al_mis)
    );

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            bus_err_q, bus_err_d;
    logic            limit_hit;

    assign limit_hit = (cnt_q >= CntW'(TIMEOUT_CYCLES - 1));
    assign expire    = limit_hit && (((state_q == StReq) && !mem_gnt) ||
                                     ((state_q == StWait) && !mem_rvalid));

    always_comb begin
        cnt_d     = cnt_q;
        bus_err_d = bus_err_q;
        if (state_q == StIdle) begin
            cnt_d = '0;
            if (req_valid) begin
                bus_err_d = 1'b0;
            end
        end else if ((state_q == StReq) || (state_q == StWait)) begin
            cnt_d = cnt_q + 1'b1;
            if (expire) begin
                bus_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign bus_err = (state_q == StDone) && bus_err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign expire             = 1'b0;
    assign bus_err            = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        off_d        = off_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        misaligned_d = misaligned_q;
        case (state_q)
            StIdle: begin
                if (req_valid) begin
                    op_d         = req_op;
                    off_d        = req_addr[1:0];
                    misaligned_d = al_mis;
                    if (al_mis) begin
                        rdata_d = '0;
                        state_d = StDone;
                    end else begin
                        mem_we_d    = !is_load(req_op);
                        mem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        mem_be_d    = al_be;
                        mem_wdata_d = al_wdata;
                        state_d     = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_gnt) begin
                    state_d = StWait;
                end else if (expire) begin
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StWait: begin
                if (mem_rvalid) begin
                    rdata_d = is_load(op_q) ? al_load : '0;
                    state_d = StDone;
                end else if (expire) begin
                    rdata_d = '0;
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= OpLb;
            off_q        <= 2'b00;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_be_q     <= '0;
            mem_wdata_q  <= '0;
            rdata_q      <= '0;
            misaligned_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            off_q        <= off_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_be_q     <= mem_be_d;
            mem_wdata_q  <= mem_wdata_d;
            rdata_q      <= rdata_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign stall      = (state_q != StIdle);
    assign done       = (state_q == StDone);
    assign misaligned = (state_q == StDone) && misaligned_q;
    assign mem_req    = (state_q == StReq);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign rdata      = rdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: aligned loads/stores, extension, misalignment, backpressure, reset.
module tb_lsu;
    import lsu_pkg::*;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    memop_e      req_op = OpLw;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        stall, done, misaligned, bus_err;
    logic [31:0] rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .stall      (stall),
        .done       (done),
        .rdata      (rdata),
        .misaligned (misaligned),
        .bus_err    (bus_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic issue(input memop_e op, input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
    endtask

    // Accept in cycle N, gnt in N+1, rvalid in N+2, expect done in N+3.
    task automatic aligned_access(input string tag, input memop_e op, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [31:0] bus_rdata,
                                  input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                  input logic exp_we, input logic [31:0] exp_wdata,
                                  input logic [31:0] exp_rdata);
        issue(op, addr, wdata);
        chk1({tag, ".ready"}, req_ready, 1'b1);
        step();
        req_valid = 1'b0;
        chk1({tag, ".stall1"}, stall, 1'b1);
        chk1({tag, ".req"}, mem_req, 1'b1);
        chk32({tag, ".addr"}, mem_addr, exp_addr);
        chk32({tag, ".be"}, {28'b0, mem_be}, {28'b0, exp_be});
        chk1({tag, ".we"}, mem_we, exp_we);
        chk32({tag, ".wdata"}, mem_wdata, exp_wdata);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk1({tag, ".req_drop"}, mem_req, 1'b0);
        chk1({tag, ".done_early"}, done, 1'b0);
        chk1({tag, ".stall2"}, stall, 1'b1);
        mem_rvalid = 1'b1;
        mem_rdata  = bus_rdata;
        step();
        mem_rvalid = 1'b0;
        chk1({tag, ".done"}, done, 1'b1);
        chk1({tag, ".stall3"}, stall, 1'b1);
        chk1({tag, ".mis"}, misaligned, 1'b0);
        chk1({tag, ".buserr"}, bus_err, 1'b0);
        chk32({tag, ".rdata"}, rdata, exp_rdata);
        step();
        chk1({tag, ".done_pulse"}, done, 1'b0);
        chk1({tag, ".idle"}, req_ready, 1'b1);
        chk32({tag, ".rdata_hold"}, rdata, exp_rdata);
    endtask

    initial begin
        step();
        chk1("rst.ready", req_ready, 1'b1);
        chk1("rst.stall", stall, 1'b0);
        chk1("rst.done", done, 1'b0);
        chk1("rst.mis", misaligned, 1'b0);
        chk1("rst.buserr", bus_err, 1'b0);
        chk1("rst.req", mem_req, 1'b0);
        chk1("rst.we", mem_we, 1'b0);
        chk32("rst.be", {28'b0, mem_be}, 32'h0);
        chk32("rst.addr", mem_addr, 32'h0);
        chk32("rst.wdata", mem_wdata, 32'h0);
        chk32("rst.rdata", rdata, 32'h0);
        rst = 1'b0;
        step();

        aligned_access("lw", OpLw, 32'h1000, 32'h0, 32'hDEADBEEF,
                       32'h1000, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF);
        aligned_access("lb", OpLb, 32'h1003, 32'h0, 32'h80FFFFFF,
                       32'h1000, 4'b1000, 1'b0, 32'h0, 32'hFFFFFF80);
        aligned_access("lbu", OpLbu, 32'h1003, 32'h0, 32'h80FFFFFF,
                       32'h1000, 4'b1000, 1'b0, 32'h0, 32'h00000080);
        aligned_access("sh", OpSh, 32'h2002, 32'h1234ABCD, 32'hFFFFFFFF,
                       32'h2000, 4'b1100, 1'b1, 32'hABCDABCD, 32'h0);
        aligned_access("sb", OpSb, 32'h3001, 32'h00000055, 32'hFFFFFFFF,
                       32'h3000, 4'b0010, 1'b1, 32'h55555555, 32'h0);
        aligned_access("sw", OpSw, 32'h4004, 32'hCAFEF00D, 32'h11111111,
                       32'h4004, 4'b1111, 1'b1, 32'hCAFEF00D, 32'h0);
        aligned_access("lh", OpLh, 32'h2002, 32'h0, 32'h80010000,
                       32'h2000, 4'b1100, 1'b0, 32'h0, 32'hFFFF8001);
        aligned_access("lhu", OpLhu, 32'h2002, 32'h0, 32'h80010000,
                       32'h2000, 4'b1100, 1'b0, 32'h0, 32'h00008001);

        // Misaligned word: done one cycle after acceptance, no bus request.
        issue(OpLw, 32'h1001, 32'h0);
        step();
        chk1("mis.done", done, 1'b1);
        chk1("mis.flag", misaligned, 1'b1);
        chk1("mis.req", mem_req, 1'b0);
        chk32("mis.rdata", rdata, 32'h0);
        // New request during DONE must wait for IDLE.
        issue(OpLw, 32'h4000, 32'h0);
        chk1("done.ready", req_ready, 1'b0);
        step();
        chk1("mis.pulse", done, 1'b0);
        chk1("mis.flag_clr", misaligned, 1'b0);
        chk1("idle.ready", req_ready, 1'b1);
        chk1("idle.req", mem_req, 1'b0);
        step();
        req_valid = 1'b0;

        for (int i = 0; i < 5; i++) begin
            chk1("bp.req", mem_req, 1'b1);
            chk32("bp.addr", mem_addr, 32'h4000);
            chk32("bp.be", {28'b0, mem_be}, 32'hF);
            chk1("bp.done", done, 1'b0);
            step();
        end
        chk1("bp.req_end", mem_req, 1'b1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk1("bp.wait_req", mem_req, 1'b0);
        chk1("bp.wait_stall", stall, 1'b1);

        // Reset while waiting for the response.
        rst = 1'b1;
        #1;
        chk1("mrst.req", mem_req, 1'b0);
        chk1("mrst.done", done, 1'b0);
        chk1("mrst.ready", req_ready, 1'b1);
        chk1("mrst.stall", stall, 1'b0);
        step();
        rst        = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h12345678;
        step();
        mem_rvalid = 1'b0;
        chk1("late_rv.done", done, 1'b0);
        chk32("late_rv.rdata", rdata, 32'h0);
        chk1("late_rv.ready", req_ready, 1'b1);

        // Misaligned halfword store.
        issue(OpSh, 32'h2001, 32'hFFFF0000);
        step();
        req_valid = 1'b0;
        chk1("missh.done", done, 1'b1);
        chk1("missh.flag", misaligned, 1'b1);
        chk1("missh.req", mem_req, 1'b0);
        step();
        chk1("missh.idle", req_ready, 1'b1);

`ifdef LSU_TIMEOUT_EN
        issue(OpLw, 32'h5000, 32'h0);
        step();
        req_valid = 1'b0;
        chk1("to.req", mem_req, 1'b1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        for (int i = 1; i < TO; i++) begin
            chk1("to.wait", done, 1'b0);
            step();
        end
        chk1("to.done", done, 1'b1);
        chk1("to.buserr", bus_err, 1'b1);
        chk32("to.rdata", rdata, 32'h0);
        step();
        chk1("to.idle", req_ready, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
